// File: rtl/rib_timer.sv
// RIB-mapped timer: prescaled up-counter with terminal value, pending flag,
// one-shot mode and level interrupt.
`timescale 1ns/1ps
module rib_timer #(
  parameter int PSC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_COUNT = 8'h04;
  localparam logic [7:0] OFF_VALUE = 8'h08;
  localparam logic [7:0] OFF_PSC   = 8'h0C;

  logic                 en_reg, en_next;
  logic                 int_en_reg, int_en_next;
  logic                 pend_reg, pend_next;
  logic                 oneshot_reg, oneshot_next;
  logic [31:0]          count_reg, count_next;
  logic [31:0]          value_reg, value_next;
  logic [PSC_WIDTH-1:0] psc_reg, psc_next;
  logic [PSC_WIDTH-1:0] psc_cnt_reg, psc_cnt_next;

  logic        wr_ctrl, wr_count, wr_value, wr_psc;
  logic        running, tick, expire;
  logic [32:0] count_inc;
  logic        unused_addr;

  assign unused_addr = ^addr_i[31:8];

  assign wr_ctrl  = we_i && (addr_i[7:0] == OFF_CTRL);
  assign wr_count = we_i && (addr_i[7:0] == OFF_COUNT);
  assign wr_value = we_i && (addr_i[7:0] == OFF_VALUE);
  assign wr_psc   = we_i && (addr_i[7:0] == OFF_PSC);

  assign running   = en_reg && (value_reg != 32'd0);
  assign tick      = running && (psc_cnt_reg == psc_reg);
  // 33-bit increment so a software-loaded 0xFFFFFFFF still compares as >= VALUE
  assign count_inc = {1'b0, count_reg} + 33'd1;
  assign expire    = tick && (count_inc >= {1'b0, value_reg});

  always_comb begin
    en_next      = en_reg;
    int_en_next  = int_en_reg;
    pend_next    = pend_reg;
    oneshot_next = oneshot_reg;
    count_next   = count_reg;
    value_next   = value_reg;
    psc_next     = psc_reg;
    psc_cnt_next = psc_cnt_reg;

    if (running) begin
      psc_cnt_next = tick ? '0 : psc_cnt_reg + 1'b1;
    end
    if (tick) begin
      count_next = expire ? 32'd0 : count_inc[31:0];
    end

    if (wr_ctrl) begin
      en_next      = data_i[0];
      int_en_next  = data_i[1];
      oneshot_next = data_i[3];
      if (data_i[2]) pend_next = 1'b0;
      if (!en_reg && data_i[0]) psc_cnt_next = '0;
    end
    if (wr_count) begin
      count_next   = data_i;
      psc_cnt_next = '0;
    end
    if (wr_value) value_next = data_i;
    if (wr_psc)   psc_next   = data_i[PSC_WIDTH-1:0];

    // Hardware events are applied last so they win over same-cycle software writes.
    if (expire) begin
      pend_next = 1'b1;
      if (oneshot_reg) en_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg      <= 1'b0;
      int_en_reg  <= 1'b0;
      pend_reg    <= 1'b0;
      oneshot_reg <= 1'b0;
      count_reg   <= 32'd0;
      value_reg   <= 32'd0;
      psc_reg     <= '0;
      psc_cnt_reg <= '0;
    end else begin
      en_reg      <= en_next;
      int_en_reg  <= int_en_next;
      pend_reg    <= pend_next;
      oneshot_reg <= oneshot_next;
      count_reg   <= count_next;
      value_reg   <= value_next;
      psc_reg     <= psc_next;
      psc_cnt_reg <= psc_cnt_next;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (addr_i[7:0])
      OFF_CTRL:  data_o = {28'd0, oneshot_reg, pend_reg, int_en_reg, en_reg};
      OFF_COUNT: data_o = count_reg;
      OFF_VALUE: data_o = value_reg;
      OFF_PSC:   data_o = 32'(psc_reg);
      default:   data_o = 32'd0;
    endcase
  end

  assign int_sig_o = pend_reg && int_en_reg;

endmodule

// File: tb/tb_rib_timer.sv
// Self-checking bench for rib_timer: expectations are queued as stimulus is
// driven and popped when the corresponding register reads are taken.
`timescale 1ns/1ps
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic        we_i = 1'b0;
  logic [31:0] data_o;
  logic        int_sig_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] rd;

  rib_timer #(.PSC_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = {24'd0, a};
    data_i = d;
    we_i   = 1'b1;
    step();
    we_i   = 1'b0;
    data_i = 32'd0;
    $display("[%0t] write off=0x%02h data=0x%08h", $time, a, d);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
    addr_i = {24'd0, a};
    #1;
    v = data_o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    we_i   = 1'b1;
    addr_i = 32'h8;
    data_i = 32'h55;
    step(2);
    we_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(8'(i * 4), rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL reset_read off=0x%02h got=0x%08h exp=0x%08h", i * 4, rd, exp_v);
      end
    end
    checks++;
    if (int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_int got=%b exp=0", int_sig_o);
    end
    rst = 1'b0;
    step();
    exp_q.push_back(32'd0);
    rd_reg(8'h08, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL reset_value_after got=0x%08h exp=0x%08h", rd, exp_v);
    end
    $display("[%0t] reset test done", $time);
  endtask

  task automatic test_periodic();
    logic [31:0] exp_p;
    do_reset();
    wr(8'h0C, 32'd0);
    wr(8'h08, 32'd5);
    wr(8'h00, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(32'(k % 5));
      exp_q.push_back((k >= 5) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      rd_reg(8'h04, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL periodic_count k=%0d got=0x%08h exp=0x%08h", k, rd, exp_v);
      end
      exp_p = exp_q.pop_front();
      rd_reg(8'h00, rd);
      checks++;
      if (rd[2] !== exp_p[0] || int_sig_o !== exp_p[0]) begin
        errors++;
        $display("FAIL periodic_pend k=%0d got pend=%b int=%b exp=%b", k, rd[2], int_sig_o, exp_p[0]);
      end
    end
    // Clear PEND at E13 (count 3); it must return exactly at E15.
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    wr(8'h00, 32'h7);
    for (int k = 13; k <= 15; k++) begin
      if (k > 13) step();
      exp_v = exp_q.pop_front();
      checks++;
      if (int_sig_o !== exp_v[0]) begin
        errors++;
        $display("FAIL periodic_repeat k=%0d got int=%b exp=%b", k, int_sig_o, exp_v[0]);
      end
    end
    $display("[%0t] periodic test done", $time);
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(8'h0C, 32'd3);
    wr(8'h08, 32'd2);
    wr(8'h00, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(32'h8 | 32'h2 | ((k >= 8) ? 32'h4 : 32'h0) | ((k < 8) ? 32'h1 : 32'h0));
      exp_q.push_back((k >= 4 && k < 8) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      rd_reg(8'h00, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v || int_sig_o !== exp_v[2]) begin
        errors++;
        $display("FAIL oneshot_ctrl k=%0d got=0x%08h int=%b exp=0x%08h", k, rd, int_sig_o, exp_v);
      end
      rd_reg(8'h04, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL oneshot_count k=%0d got=0x%08h exp=0x%08h", k, rd, exp_v);
      end
    end
    $display("[%0t] oneshot test done", $time);
  endtask

  task automatic test_w1c_race();
    do_reset();
    wr(8'h0C, 32'd0);
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h3);
    step(2);
    // Expected after each W1C write: {CTRL, int, COUNT}.
    exp_q.push_back(32'h7); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'h3); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    for (int i = 0; i < 2; i++) begin
      wr(8'h00, 32'h7);
      rd_reg(8'h00, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL w1c_ctrl step=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (int_sig_o !== exp_v[0]) begin
        errors++;
        $display("FAIL w1c_int step=%0d got=%b exp=%b", i, int_sig_o, exp_v[0]);
      end
      rd_reg(8'h04, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL w1c_count step=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
    end
    $display("[%0t] w1c race test done", $time);
  endtask

  task automatic test_count_override();
    do_reset();
    wr(8'h0C, 32'd0);
    wr(8'h08, 32'd4);
    wr(8'h00, 32'h1);
    exp_q.push_back(32'h10); exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h5);
    wr(8'h04, 32'h10);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      rd_reg(8'h04, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL override_count step=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
      rd_reg(8'h00, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL override_ctrl step=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
    end
    checks++;
    if (int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL override_int_masked got=%b exp=0", int_sig_o);
    end
    $display("[%0t] count override test done", $time);
  endtask

  task automatic test_decode_reset();
    do_reset();
    wr(8'h0C, 32'd2);
    wr(8'h08, 32'd100);
    wr(8'h00, 32'h3);
    wr(8'h10, 32'hFFFF_FFFF);
    exp_q.push_back(32'h3); exp_q.push_back(32'h0);
    exp_q.push_back(32'd100); exp_q.push_back(32'd2); exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      rd_reg(8'(i * 4), rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL decode_read off=0x%02h got=0x%08h exp=0x%08h", i * 4, rd, exp_v);
      end
    end
    step(9);
    exp_q.push_back(32'd3);
    rd_reg(8'h04, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL decode_midcount got=0x%08h exp=0x%08h", rd, exp_v);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(8'(i * 4), rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL midreset_read off=0x%02h got=0x%08h exp=0x%08h", i * 4, rd, exp_v);
      end
    end
    step(30);
    exp_q.push_back(32'd0);
    rd_reg(8'h00, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v || int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL postreset_idle got ctrl=0x%08h int=%b exp ctrl=0x%08h int=0", rd, int_sig_o, exp_v);
    end
    $display("[%0t] decode/reset test done", $time);
  endtask

  task automatic test_edge_cases();
    do_reset();
    wr(8'h08, 32'd0);
    wr(8'h04, 32'd7);
    wr(8'h00, 32'h3);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'd7);
      exp_q.push_back(32'h3);
    end
    for (int i = 0; i < 5; i++) begin
      step(10);
      rd_reg(8'h04, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL value0_count iter=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
      rd_reg(8'h00, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++;
        $display("FAIL value0_ctrl iter=%0d got=0x%08h exp=0x%08h", i, rd, exp_v);
      end
    end
    // VALUE write must leave COUNT alone; counting resumes on the next edge.
    exp_q.push_back(32'd100); exp_q.push_back(32'd7); exp_q.push_back(32'd8);
    wr(8'h08, 32'd100);
    rd_reg(8'h08, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL value_write got=0x%08h exp=0x%08h", rd, exp_v);
    end
    rd_reg(8'h04, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL value_write_count got=0x%08h exp=0x%08h", rd, exp_v);
    end
    step();
    rd_reg(8'h04, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL resume_count got=0x%08h exp=0x%08h", rd, exp_v);
    end
    exp_q.push_back(32'h0000_FFFF);
    wr(8'h0C, 32'hFFFF_FFFF);
    rd_reg(8'h0C, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++;
      $display("FAIL prescale_width got=0x%08h exp=0x%08h", rd, exp_v);
    end
    $display("[%0t] edge case test done", $time);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c_race();
    test_count_override();
    test_decode_reset();
    test_edge_cases();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_timer.md
RIB_TIMER -- requirements
Module: rib_timer

Interface
REQ-001 SHALL have parameter PSC_WIDTH, default 16, width of prescaler field and prescaler counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port addr_i  input  32  RIB slave address; region nibble already stripped by bus, only addr_i[7:0] decoded.
REQ-005 SHALL have port data_i  input  32  RIB write data.
REQ-006 SHALL have port we_i  input  1  RIB write strobe; write committed at rising edge while high.
REQ-007 SHALL have port data_o  output  32  RIB read data, combinational from addr_i and register state.
REQ-008 SHALL have port int_sig_o  output  1  level interrupt to core, = CTRL.PEND & CTRL.INT_EN.

Function
REQ-009 SHALL decode byte offsets: 0x00 CTRL, 0x04 COUNT, 0x08 VALUE, 0x0C PRESCALE; other offsets read 0, writes ignored.
REQ-010 CTRL bits SHALL be: [0] EN, [1] INT_EN, [2] PEND (read 1 = pending; write 1 clears, write 0 no effect), [3] ONESHOT; bits [31:4] read 0.
REQ-011 COUNT SHALL be a 32-bit read/write up-counter; VALUE a 32-bit read/write terminal value; PRESCALE PSC_WIDTH bits read/write, upper bits read 0.
REQ-012 Reads SHALL be zero-latency (same-cycle combinational); writes SHALL be visible on data_o the cycle after the write edge.
REQ-013 Internal prescaler counter psc_cnt SHALL count while EN=1 and VALUE!=0; tick asserts for one cycle when psc_cnt==PRESCALE, psc_cnt then returns to 0.
REQ-014 Tick period SHALL be PRESCALE+1 clk cycles; PRESCALE=0 gives a tick every cycle.
REQ-015 On tick, if COUNT+1 >= VALUE: COUNT <= 0, PEND <= 1, and if ONESHOT=1 then EN <= 0; otherwise COUNT <= COUNT+1.
REQ-016 Pend period in periodic mode SHALL be VALUE*(PRESCALE+1) cycles from enable.
REQ-017 VALUE=0 SHALL freeze COUNT and psc_cnt, never set PEND.
REQ-018 EN=0 SHALL hold COUNT and psc_cnt; write of CTRL with EN 0->1 SHALL clear psc_cnt.
REQ-019 Write to COUNT SHALL load data_i, clear psc_cnt, and override any same-cycle tick update of COUNT.
REQ-020 Same-cycle PEND set by hardware and W1C from software: set SHALL win (PEND=1 after edge).
REQ-021 Same-cycle one-shot expiry and CTRL write with EN=1: hardware EN clear SHALL win.
REQ-022 COUNT set above VALUE by software SHALL wrap to 0 with PEND on next tick (>= compare).
REQ-023 Writing VALUE SHALL NOT reset COUNT or psc_cnt.
REQ-024 int_sig_o SHALL be purely combinational from PEND and INT_EN; no extra delay.

Reset
REQ-025 rst=1 at a rising edge SHALL clear CTRL, COUNT, VALUE, PRESCALE, psc_cnt to 0, taking priority over any write or tick that cycle.
REQ-026 During and after reset int_sig_o SHALL be 0 and data_o SHALL read 0 at all decoded offsets.
REQ-027 Reset asserted mid-count SHALL abandon the count; no PEND after release until reprogrammed.

Verification
REQ-028 Periodic: PRESCALE=0, VALUE=5, CTRL=0x3 -> PEND and int_sig_o rise 5 cycles after enable write, repeat every 5 cycles, COUNT 0..4 sequence.
REQ-029 Prescaled one-shot: PRESCALE=3, VALUE=2, CTRL=0xB -> PEND at cycle 8 after enable, EN reads 0, COUNT stays 0 thereafter.
REQ-030 W1C race: write CTRL=0x7 on the exact tick edge setting PEND -> PEND reads 1 next cycle; W1C one cycle later -> PEND 0, int_sig_o 0.
REQ-031 COUNT override: write COUNT=0x10 with VALUE=4 during tick -> COUNT reads 0x10, next tick COUNT=0 and PEND=1.
REQ-032 Decode/reset: write 0xFFFFFFFF to offset 0x10 -> all registers unchanged; assert rst mid-count with VALUE=100 -> all offsets read 0, int_sig_o 0.
REQ-033 Edge cases: VALUE=0 with EN=1 for 50 cycles -> COUNT constant, PEND 0; PRESCALE write 0xFFFFFFFF -> reads 0x0000FFFF.
